// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter -- iterative AES-128 decryption core.
// Accepts one ciphertext block plus cipher key, runs the key schedule forward
// to round key 10, then performs one inverse round per clock while stepping
// the key schedule backwards. Byte 0 of the state is bits [127:120], column-major.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only while idle)
//   key, ciphertext   128-bit inputs, sampled on the accepting edge
//   out_valid/out_ready output handshake (result held until taken)
//   plaintext         128-bit result, stable while out_valid
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the last key and its
// round key 10, so a block with a repeated key skips the forward schedule.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   r_q, r_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] st_q, st_d;

    logic [31:0]  sw_in, sw_out;
    logic [3:0]   rcon_idx;
    logic [127:0] fwd_rk, inv_rk, dec_core;
    logic         cache_hit;
    logic [127:0] cached_rk10;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) t = gf_mul(gf_mul(t, t), a);
        return gf_mul(t, t);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // InvShiftRows followed by InvSubBytes; element 15 of the packed view is byte 0.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [15:0][7:0] a, o;
        a = s;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4'(15 - 4*c - r)] = inv_sbox(a[4'(15 - 4*((c - r + 4) % 4) - r)]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [15:0][7:0] a, o;
        logic [7:0] a0, a1, a2, a3;
        a = s;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = a[4'(15 - 4*c)];
            a1 = a[4'(14 - 4*c)];
            a2 = a[4'(13 - 4*c)];
            a3 = a[4'(12 - 4*c)];
            o[4'(15 - 4*c)] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[4'(14 - 4*c)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[4'(13 - 4*c)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[4'(12 - 4*c)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Shared key-schedule S-boxes: forward expansion rotates word 3 of rk_q,
    // the inverse step first recovers the previous word 3 (w3 ^ w2) and rotates that.
    always_comb begin
        logic [31:0] f0, f1, f2;
        sw_in    = (fsm_q == DEC) ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
        rcon_idx = (fsm_q == DEC) ? (r_q + 4'd1) : r_q;
        sw_out   = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon(rcon_idx), 24'h000000};

        f0 = rk_q[127:96] ^ sw_out;
        f1 = rk_q[95:64] ^ f0;
        f2 = rk_q[63:32] ^ f1;
        fwd_rk = {f0, f1, f2, rk_q[31:0] ^ f2};

        inv_rk = {rk_q[127:96] ^ sw_out, rk_q[95:64] ^ rk_q[127:96],
                  rk_q[63:32] ^ rk_q[95:64], rk_q[31:0] ^ rk_q[63:32]};

        dec_core = inv_sub_shift(st_q) ^ inv_rk;
    end

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_vld_q, cache_vld_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk10_q, cache_rk10_d;
    logic [127:0] key_q, key_d;

    // The cache is refreshed on every pass through the forward schedule.
    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_key_d  = cache_key_q;
        cache_rk10_d = cache_rk10_q;
        key_d        = key_q;
        if (fsm_q == IDLE && in_valid) key_d = key;
        if (fsm_q == KEXP && r_q == 4'd10) begin
            cache_vld_d  = 1'b1;
            cache_key_d  = key_q;
            cache_rk10_d = fwd_rk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld_q  <= 1'b0;
            cache_key_q  <= '0;
            cache_rk10_q <= '0;
            key_q        <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_key_q  <= cache_key_d;
            cache_rk10_q <= cache_rk10_d;
            key_q        <= key_d;
        end
    end

    assign cache_hit   = cache_vld_q && (key == cache_key_q);
    assign cached_rk10 = cache_rk10_q;
`else
    assign cache_hit   = 1'b0;
    assign cached_rk10 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
            r_q   <= '0;
            rk_q  <= '0;
            ct_q  <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            r_q   <= r_d;
            rk_q  <= rk_d;
            ct_q  <= ct_d;
            st_q  <= st_d;
        end
    end

    // Next state and datapath; rk_q always holds the round key for the next step.
    always_comb begin
        fsm_d = fsm_q;
        r_d   = r_q;
        rk_d  = rk_q;
        ct_d  = ct_q;
        st_d  = st_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    if (cache_hit) begin
                        st_d  = ciphertext ^ cached_rk10;
                        rk_d  = cached_rk10;
                        r_d   = 4'd9;
                        fsm_d = DEC;
                    end else begin
                        rk_d  = key;
                        ct_d  = ciphertext;
                        r_d   = 4'd1;
                        fsm_d = KEXP;
                    end
                end
            end
            KEXP: begin
                rk_d = fwd_rk;
                r_d  = r_q + 4'd1;
                if (r_q == 4'd10) begin
                    st_d  = ct_q ^ fwd_rk;
                    r_d   = 4'd9;
                    fsm_d = DEC;
                end
            end
            DEC: begin
                rk_d = inv_rk;
                if (r_q == 4'd0) begin
                    st_d  = dec_core;
                    fsm_d = DONE;
                end else begin
                    st_d = inv_mix_columns(dec_core);
                    r_d  = r_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        plaintext = st_q;
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter -- self-checking bench for aes_decrypt_iter.
// Golden plaintexts come from FIPS-197 vectors and from an AES-128
// encryption model (random plaintext encrypted, DUT must recover it).
// Honours AES_DEC_KEY_CACHE_EN for the expected latency of repeated keys.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] expQ [$];
    logic [7:0]   sboxT [256];
    int           errors = 0;
    int           checks = 0;
    logic         cacheValid = 1'b0;
    logic [127:0] cacheKey = '0;

    always #5 clk = ~clk;

    aes_decrypt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    // S-box built by walking the multiplicative group with generator 3.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sboxT[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxT[0] = 8'h63;
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] expandRef(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = rk[31:0];
        t  = {sboxT[w3[23:16]] ^ rc, sboxT[w3[15:8]], sboxT[w3[7:0]], sboxT[w3[31:24]]};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        return {w0, w1, w2, rk[31:0] ^ w2};
    endfunction

    function automatic logic [127:0] encryptRef(input logic [127:0] k, input logic [127:0] pt);
        logic [15:0][7:0] s, o;
        logic [127:0] rk;
        logic [7:0] rc, a0, a1, a2, a3;
        s  = pt ^ k;
        rk = k;
        rc = 8'h01;
        for (int round = 1; round <= 10; round++) begin
            rk = expandRef(rk, rc);
            rc = mul2(rc);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[4'(15 - 4*c - r)] = sboxT[s[4'(15 - 4*((c + r) % 4) - r)]];
            if (round != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = o[4'(15 - 4*c)];
                    a1 = o[4'(14 - 4*c)];
                    a2 = o[4'(13 - 4*c)];
                    a3 = o[4'(12 - 4*c)];
                    o[4'(15 - 4*c)] = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
                    o[4'(14 - 4*c)] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
                    o[4'(13 - 4*c)] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
                    o[4'(12 - 4*c)] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
                end
            end
            s = o ^ rk;
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Cache model: a hit only when the key matches the last key that ran the full schedule.
    function automatic int predictLatency(input logic [127:0] k);
        logic hit;
        hit = cacheValid && (k == cacheKey);
        if (!hit) begin
            cacheValid = 1'b1;
            cacheKey   = k;
        end
`ifdef AES_DEC_KEY_CACHE_EN
        return hit ? 10 : 20;
`else
        return 20;
`endif
    endfunction

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one block for exactly one accepting edge,
    // records the expected plaintext, then scrambles the inputs.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c,
                                 input logic [127:0] p, output int expLat);
        int n;
        n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                checkInt("in_ready wait cycles", n, 0);
                finishRun();
            end
        end
        in_valid   = 1'b1;
        key        = k;
        ciphertext = c;
        expQ.push_back(p);
        expLat = predictLatency(k);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        key        = rand128();
        ciphertext = rand128();
    endtask

    // Measures accept-to-valid latency, applies `stall` cycles of back-pressure
    // with stray in_valid pulses, then compares and takes the result.
    task automatic checkOutput(input int expLat, input int stall,
                               input logic chkRk, input logic [127:0] expRk);
        int n;
        logic stallOk;
        logic [127:0] held, expPt;
        n = 0;
        while (!out_valid) begin
            @(posedge clk); #1;
            n++;
            if (chkRk && n == 10) check128("rk10", dut.rk_q, expRk);
            if (n > 60) begin
                checkInt("out_valid latency (timeout)", n, expLat);
                finishRun();
            end
        end
        checkInt("latency", n, expLat);
        held    = plaintext;
        stallOk = 1'b1;
        for (int i = 0; i < stall; i++) begin
            in_valid   = ($urandom_range(0, 1) == 1);
            key        = rand128();
            ciphertext = rand128();
            @(posedge clk); #1;
            if (!out_valid || in_ready || plaintext !== held) stallOk = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) checkBit("held under back-pressure", stallOk, 1'b1);
        checkInt("scoreboard depth", expQ.size(), 1);
        expPt = (expQ.size() > 0) ? expQ.pop_front() : '0;
        check128("plaintext", plaintext, expPt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkBit("out_valid after take", out_valid, 1'b0);
        checkBit("in_ready after take", in_ready, 1'b1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        cacheValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        checkInt("watchdog expired", 1, 0);
        finishRun();
    end

    initial begin
        int lat;
        logic [127:0] k, p, prevK;

        buildSbox();
        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{key: '0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, pt: '0};
        vecs[3] = '{key: '1, ct: encryptRef('1, '1), pt: '1};
        vecs[4] = '{key: '0, ct: encryptRef('0, {1'b1, 127'b0}), pt: {1'b1, 127'b0}};
        vecs[5] = '{key: 128'h0123456789abcdeffedcba9876543210,
                    ct:  encryptRef(128'h0123456789abcdeffedcba9876543210, 128'hdeadbeef00000000cafef00d12345678),
                    pt:  128'hdeadbeef00000000cafef00d12345678};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        key        = '0;
        ciphertext = '0;
        repeat (3) @(posedge clk);
        #1;
        checkBit("reset in_ready", in_ready, 1'b1);
        checkBit("reset out_valid", out_valid, 1'b0);
        check128("reset plaintext", plaintext, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].key, vecs[i].ct, vecs[i].pt, lat);
            checkOutput(lat, 0, (i == 1), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        $display("[TB] back-pressure");
        applyStimulus(vecs[1].key, vecs[1].ct, vecs[1].pt, lat);
        checkOutput(lat, 15, 1'b0, '0);

        $display("[TB] reset during decryption");
        in_valid   = 1'b1;
        key        = vecs[0].key;
        ciphertext = vecs[0].ct;
        void'(predictLatency(vecs[0].key));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        cacheValid = 1'b0;
        #1;
        checkBit("abort out_valid", out_valid, 1'b0);
        checkBit("abort in_ready", in_ready, 1'b1);
        check128("abort plaintext", plaintext, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(vecs[0].key, vecs[0].ct, vecs[0].pt, lat);
        checkOutput(lat, 0, 1'b0, '0);

        $display("[TB] key reuse sequence");
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(vecs[1].key, vecs[1].ct, vecs[1].pt, lat);
            checkOutput(lat, 0, 1'b0, '0);
        end
        applyStimulus(vecs[0].key, vecs[0].ct, vecs[0].pt, lat);
        checkOutput(lat, 0, 1'b0, '0);
        pulseReset();
        applyStimulus(vecs[0].key, vecs[0].ct, vecs[0].pt, lat);
        checkOutput(lat, 0, 1'b0, '0);

        $display("[TB] random blocks");
        prevK = vecs[0].key;
        for (int i = 0; i < 1000; i++) begin
            k = ($urandom_range(0, 7) == 0) ? prevK : rand128();
            p = rand128();
            prevK = k;
            applyStimulus(k, encryptRef(k, p), p, lat);
            checkOutput(lat, $urandom_range(0, 3), 1'b0, '0);
        end

        checkInt("scoreboard empty", expQ.size(), 0);
        finishRun();
    end

endmodule
